// File: rtl/tlul_dw64_to_dw32_bridge_if.sv
// Bundles the 64-bit upstream TL-UL port and the 32-bit downstream TL-UL port.
// Signal suffixes are written from the bridge's point of view.
// The slave modport is the bridge; the master modport is its environment,
// which drives upstream requests and answers downstream beats.
interface tlul_dw64_to_dw32_bridge_if #(
    parameter int AW  = 32,
    parameter int AIW = 8
);
    logic           up_a_valid_i;
    logic           up_a_ready_o;
    logic [2:0]     up_a_opcode_i;
    logic [1:0]     up_a_size_i;
    logic [AIW-1:0] up_a_source_i;
    logic [AW-1:0]  up_a_address_i;
    logic [7:0]     up_a_mask_i;
    logic [63:0]    up_a_data_i;

    logic           up_d_valid_o;
    logic           up_d_ready_i;
    logic [2:0]     up_d_opcode_o;
    logic [1:0]     up_d_size_o;
    logic [AIW-1:0] up_d_source_o;
    logic [63:0]    up_d_data_o;
    logic           up_d_error_o;

    logic           dn_a_valid_o;
    logic           dn_a_ready_i;
    logic [2:0]     dn_a_opcode_o;
    logic [1:0]     dn_a_size_o;
    logic [AIW-1:0] dn_a_source_o;
    logic [AW-1:0]  dn_a_address_o;
    logic [3:0]     dn_a_mask_o;
    logic [31:0]    dn_a_data_o;

    logic           dn_d_valid_i;
    logic           dn_d_ready_o;
    logic [31:0]    dn_d_data_i;
    logic           dn_d_error_i;

    modport slave (
        input  up_a_valid_i, up_a_opcode_i, up_a_size_i, up_a_source_i,
               up_a_address_i, up_a_mask_i, up_a_data_i, up_d_ready_i,
               dn_a_ready_i, dn_d_valid_i, dn_d_data_i, dn_d_error_i,
        output up_a_ready_o, up_d_valid_o, up_d_opcode_o, up_d_size_o,
               up_d_source_o, up_d_data_o, up_d_error_o,
               dn_a_valid_o, dn_a_opcode_o, dn_a_size_o, dn_a_source_o,
               dn_a_address_o, dn_a_mask_o, dn_a_data_o, dn_d_ready_o
    );

    modport master (
        output up_a_valid_i, up_a_opcode_i, up_a_size_i, up_a_source_i,
               up_a_address_i, up_a_mask_i, up_a_data_i, up_d_ready_i,
               dn_a_ready_i, dn_d_valid_i, dn_d_data_i, dn_d_error_i,
        input  up_a_ready_o, up_d_valid_o, up_d_opcode_o, up_d_size_o,
               up_d_source_o, up_d_data_o, up_d_error_o,
               dn_a_valid_o, dn_a_opcode_o, dn_a_size_o, dn_a_source_o,
               dn_a_address_o, dn_a_mask_o, dn_a_data_o, dn_d_ready_o
    );
endinterface

// File: rtl/tlul_dw64_to_dw32_bridge.sv
// 64-bit to 32-bit TL-UL width adapter.
// Splits each upstream request into a lower and/or upper 32-bit beat (lower
// first), merges the returned words and errors, and answers with a single
// 64-bit response. Only one upstream transaction is in flight at a time.
module tlul_dw64_to_dw32_bridge #(
    parameter int AW  = 32,
    parameter int AIW = 8
) (
    input logic                       clk_i,
    input logic                       rst_ni,
    tlul_dw64_to_dw32_bridge_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LO_REQ = 3'd1,
        LO_RSP = 3'd2,
        HI_REQ = 3'd3,
        HI_RSP = 3'd4,
        RESP   = 3'd5
    } state_e;

    localparam logic [2:0] OP_PUT_FULL    = 3'd0;
    localparam logic [2:0] OP_PUT_PARTIAL = 3'd1;
    localparam logic [2:0] OP_GET         = 3'd4;

    state_e         state_q, state_d;
    logic [2:0]     opcode_q, opcode_d;
    logic [1:0]     size_q, size_d;
    logic [AIW-1:0] source_q, source_d;
    logic [AW-4:0]  addr_hi_q, addr_hi_d;
    logic [1:0]     addr_lo_q, addr_lo_d;
    logic [7:0]     mask_q, mask_d;
    logic [63:0]    wdata_q, wdata_d;
    logic [63:0]    rdata_q, rdata_d;
    logic           error_q, error_d;

    logic           illegal;
    logic           beat_hi;
    logic [3:0]     beat_mask;

    // A request is rejected for an unknown opcode, an empty mask or a misaligned word/dword access
    always_comb begin
        illegal = 1'b0;
        if ((bus.up_a_opcode_i != OP_PUT_FULL) && (bus.up_a_opcode_i != OP_PUT_PARTIAL) &&
            (bus.up_a_opcode_i != OP_GET)) begin
            illegal = 1'b1;
        end
        if (bus.up_a_mask_i == 8'h00) begin
            illegal = 1'b1;
        end
        if ((bus.up_a_size_i == 2'd3) && (bus.up_a_address_i[2:0] != 3'b000)) begin
            illegal = 1'b1;
        end
        if ((bus.up_a_size_i == 2'd2) && (bus.up_a_address_i[1:0] != 2'b00)) begin
            illegal = 1'b1;
        end
    end

    // Next-state logic: latch the request, sequence the beats, merge responses
    always_comb begin
        state_d   = state_q;
        opcode_d  = opcode_q;
        size_d    = size_q;
        source_d  = source_q;
        addr_hi_d = addr_hi_q;
        addr_lo_d = addr_lo_q;
        mask_d    = mask_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        error_d   = error_q;
        case (state_q)
            IDLE: begin
                if (bus.up_a_valid_i) begin
                    opcode_d  = bus.up_a_opcode_i;
                    size_d    = bus.up_a_size_i;
                    source_d  = bus.up_a_source_i;
                    addr_hi_d = bus.up_a_address_i[AW-1:3];
                    addr_lo_d = bus.up_a_address_i[1:0];
                    mask_d    = bus.up_a_mask_i;
                    wdata_d   = bus.up_a_data_i;
                    rdata_d   = '0;
                    error_d   = illegal;
                    if (illegal) begin
                        state_d = RESP;
                    end else if (|bus.up_a_mask_i[3:0]) begin
                        state_d = LO_REQ;
                    end else begin
                        state_d = HI_REQ;
                    end
                end
            end
            LO_REQ: begin
                if (bus.dn_a_ready_i) begin
                    state_d = LO_RSP;
                end
            end
            LO_RSP: begin
                if (bus.dn_d_valid_i) begin
                    rdata_d[31:0] = bus.dn_d_data_i;
                    error_d       = error_q | bus.dn_d_error_i;
                    state_d       = (|mask_q[7:4]) ? HI_REQ : RESP;
                end
            end
            HI_REQ: begin
                if (bus.dn_a_ready_i) begin
                    state_d = HI_RSP;
                end
            end
            HI_RSP: begin
                if (bus.dn_d_valid_i) begin
                    rdata_d[63:32] = bus.dn_d_data_i;
                    error_d        = error_q | bus.dn_d_error_i;
                    state_d        = RESP;
                end
            end
            RESP: begin
                if (bus.up_d_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and transaction registers; reset aborts any transaction in flight
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            opcode_q  <= '0;
            size_q    <= '0;
            source_q  <= '0;
            addr_hi_q <= '0;
            addr_lo_q <= '0;
            mask_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            opcode_q  <= opcode_d;
            size_q    <= size_d;
            source_q  <= source_d;
            addr_hi_q <= addr_hi_d;
            addr_lo_q <= addr_lo_d;
            mask_q    <= mask_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            error_q   <= error_d;
        end
    end

    assign beat_hi   = (state_q == HI_REQ);
    assign beat_mask = beat_hi ? mask_q[7:4] : mask_q[3:0];

    assign bus.up_a_ready_o = (state_q == IDLE);

    assign bus.dn_a_valid_o   = (state_q == LO_REQ) || (state_q == HI_REQ);
    assign bus.dn_a_opcode_o  = (opcode_q == OP_GET) ? OP_GET :
                                ((beat_mask == 4'hF) ? OP_PUT_FULL : OP_PUT_PARTIAL);
    assign bus.dn_a_size_o    = (size_q == 2'd3) ? 2'd2 : size_q;
    assign bus.dn_a_source_o  = source_q;
    assign bus.dn_a_address_o = {addr_hi_q, beat_hi, addr_lo_q};
    assign bus.dn_a_mask_o    = beat_mask;
    assign bus.dn_a_data_o    = beat_hi ? wdata_q[63:32] : wdata_q[31:0];
    assign bus.dn_d_ready_o   = (state_q == LO_RSP) || (state_q == HI_RSP);

    assign bus.up_d_valid_o  = (state_q == RESP);
    assign bus.up_d_opcode_o = (opcode_q == OP_GET) ? 3'd1 : 3'd0;
    assign bus.up_d_size_o   = size_q;
    assign bus.up_d_source_o = source_q;
    assign bus.up_d_data_o   = (opcode_q == OP_GET) ? rdata_q : 64'h0;
    assign bus.up_d_error_o  = error_q;
endmodule

// File: tb/tb_tlul_dw64_to_dw32_bridge.sv
// Testbench for tlul_dw64_to_dw32_bridge: a directed table of transactions with
// hand-computed expectations, a mid-transaction reset sequence, and randomized
// transactions checked against a transaction-level reference model.
module tb_tlul_dw64_to_dw32_bridge;
    localparam int AW  = 32;
    localparam int AIW = 8;

    typedef struct packed {
        logic [2:0]  op;
        logic [1:0]  size;
        logic [7:0]  src;
        logic [31:0] addr;
        logic [7:0]  mask;
        logic [63:0] data;
    } reqT;

    typedef struct packed {
        logic [31:0] addr;
        logic [1:0]  size;
        logic [3:0]  mask;
        logic [2:0]  op;
        logic [31:0] data;
        logic [7:0]  src;
    } beatT;

    typedef struct {
        int          nBeats;
        beatT [1:0]  beats;
        logic [2:0]  uOp;
        logic [1:0]  uSize;
        logic [7:0]  uSrc;
        logic [63:0] uData;
        logic        uErr;
        int          latency;
        int          unstable;
        int          acceptWait;
        int          timedOut;
        logic        validAfter;
    } obsT;

    typedef struct {
        int          nBeats;
        beatT [1:0]  beats;
        logic [2:0]  uOp;
        logic [63:0] uData;
        logic        uErr;
    } expT;

    typedef struct {
        reqT         req;
        logic [31:0] w0;
        logic [31:0] w1;
        logic        e0;
        logic        e1;
        int          aDly;
        int          upDly;
        int          expBeats;
        logic [31:0] expAddr0;
        logic [31:0] expAddr1;
        logic [3:0]  expMask0;
        logic [2:0]  expOp0;
        logic [1:0]  expSize0;
        logic [31:0] expData0;
        logic [2:0]  expUpOp;
        logic [63:0] expUpData;
        logic        expUpErr;
        int          expLat;
    } vecT;

    logic clk_i;
    logic rst_ni;
    int   checkCount;
    int   passCount;

    tlul_dw64_to_dw32_bridge_if #(.AW(AW), .AIW(AIW)) bus ();

    tlul_dw64_to_dw32_bridge #(.AW(AW), .AIW(AIW)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    // Free-running clock
    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // Hard stop in case something hangs outside the bounded loops
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        checkCount++;
        if (act === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Transaction-level model: which beats appear and what the merged response is
    function automatic expT model(input reqT r, input logic [31:0] w0, input logic [31:0] w1,
                                  input logic e0, input logic e1);
        expT         e;
        beatT        bt;
        logic [3:0]  nib;
        logic [31:0] word;
        logic        err;
        e.nBeats = 0;
        e.beats  = '0;
        e.uErr   = 1'b0;
        e.uData  = 64'h0;
        e.uOp    = (r.op == 3'd4) ? 3'd1 : 3'd0;
        if (!(r.op == 3'd0 || r.op == 3'd1 || r.op == 3'd4) || r.mask == 8'h00 ||
            (r.size == 2'd3 && (r.addr % 8) != 0) || (r.size == 2'd2 && (r.addr % 4) != 0)) begin
            e.uErr = 1'b1;
            return e;
        end
        for (int b = 0; b < 2; b++) begin
            nib  = 4'((r.mask >> (4 * b)) & 8'h0F);
            word = (b == 0) ? w0 : w1;
            err  = (b == 0) ? e0 : e1;
            if (nib != 4'h0) begin
                bt.addr = 32'((r.addr / 8) * 8 + 4 * b + (r.addr % 4));
                bt.size = (r.size > 2'd2) ? 2'd2 : r.size;
                bt.mask = nib;
                bt.op   = (r.op == 3'd4) ? 3'd4 : ((nib == 4'hF) ? 3'd0 : 3'd1);
                bt.data = 32'(r.data >> (32 * b));
                bt.src  = r.src;
                if (e.nBeats == 0) e.beats[0] = bt;
                else               e.beats[1] = bt;
                e.nBeats++;
                if (r.op == 3'd4) e.uData = e.uData | (64'(word) << (32 * b));
                e.uErr = e.uErr | err;
            end
        end
        return e;
    endfunction

    // Drives one upstream request and plays the downstream device; caller is just past a negedge
    task automatic applyStimulus(input reqT r, input logic [31:0] w0, input logic [31:0] w1,
                                 input logic e0, input logic e1, input int aDly, input int dDly,
                                 input int upDly, input bit noise, output obsT o);
        int          cyc;
        int          aWait;
        int          dWait;
        int          upWait;
        bit          done;
        bit          aSeen;
        bit          upSeen;
        bit          curHi;
        beatT        snap;
        beatT        aSnap;
        logic [77:0] uSnap;
        logic [77:0] uFirst;
        o.nBeats = 0; o.beats = '0; o.uOp = '0; o.uSize = '0; o.uSrc = '0; o.uData = '0;
        o.uErr = 1'b0; o.latency = 0; o.unstable = 0; o.acceptWait = 0; o.timedOut = 0;
        o.validAfter = 1'b0;
        aWait = 0; dWait = 0; upWait = 0; done = 0; aSeen = 0; upSeen = 0; curHi = 0;
        aSnap = '0; uFirst = '0;
        bus.up_a_valid_i   = 1'b1;
        bus.up_a_opcode_i  = r.op;
        bus.up_a_size_i    = r.size;
        bus.up_a_source_i  = r.src;
        bus.up_a_address_i = r.addr;
        bus.up_a_mask_i    = r.mask;
        bus.up_a_data_i    = r.data;
        while (!bus.up_a_ready_o && o.acceptWait < 50) begin
            @(negedge clk_i);
            o.acceptWait++;
        end
        @(posedge clk_i);
        cyc = 1;
        while (!done && cyc < 300) begin
            @(negedge clk_i);
            if (noise) begin
                bus.up_a_valid_i   = 1'b1;
                bus.up_a_opcode_i  = 3'd4;
                bus.up_a_size_i    = 2'($urandom_range(0, 3));
                bus.up_a_source_i  = 8'($urandom);
                bus.up_a_address_i = $urandom;
                bus.up_a_mask_i    = 8'($urandom);
                bus.up_a_data_i    = {$urandom, $urandom};
            end else begin
                bus.up_a_valid_i = 1'b0;
            end
            bus.dn_a_ready_i = 1'b0;
            if (bus.dn_a_valid_o) begin
                snap = {bus.dn_a_address_o, bus.dn_a_size_o, bus.dn_a_mask_o,
                        bus.dn_a_opcode_o, bus.dn_a_data_o, bus.dn_a_source_o};
                if (!aSeen) begin
                    aSnap = snap;
                    aSeen = 1;
                end else if (snap !== aSnap) begin
                    o.unstable++;
                end
                if (aWait >= aDly) begin
                    bus.dn_a_ready_i = 1'b1;
                    if (o.nBeats == 0)      o.beats[0] = snap;
                    else if (o.nBeats == 1) o.beats[1] = snap;
                    o.nBeats++;
                    curHi = bus.dn_a_address_o[2];
                    aSeen = 0;
                    aWait = 0;
                end else begin
                    aWait++;
                end
            end
            bus.dn_d_valid_i = 1'b0;
            bus.dn_d_data_i  = $urandom;
            bus.dn_d_error_i = 1'b0;
            if (bus.dn_d_ready_o) begin
                if (dWait >= dDly) begin
                    bus.dn_d_valid_i = 1'b1;
                    bus.dn_d_data_i  = curHi ? w1 : w0;
                    bus.dn_d_error_i = curHi ? e1 : e0;
                    dWait = 0;
                end else begin
                    dWait++;
                end
            end else if (noise) begin
                bus.dn_d_valid_i = 1'b1;
                bus.dn_d_error_i = 1'b1;
            end
            bus.up_d_ready_i = 1'b0;
            if (bus.up_d_valid_o) begin
                uSnap = {bus.up_d_opcode_o, bus.up_d_size_o, bus.up_d_source_o,
                         bus.up_d_data_o, bus.up_d_error_o};
                if (!upSeen) begin
                    uFirst    = uSnap;
                    upSeen    = 1;
                    o.latency = cyc;
                end else if (uSnap !== uFirst) begin
                    o.unstable++;
                end
                if (upWait >= upDly) begin
                    bus.up_d_ready_i = 1'b1;
                    bus.up_a_valid_i = 1'b0;
                    o.uOp   = bus.up_d_opcode_o;
                    o.uSize = bus.up_d_size_o;
                    o.uSrc  = bus.up_d_source_o;
                    o.uData = bus.up_d_data_o;
                    o.uErr  = bus.up_d_error_o;
                    done    = 1;
                end else begin
                    upWait++;
                end
            end
            @(posedge clk_i);
            cyc++;
        end
        if (!done) o.timedOut = 1;
        @(negedge clk_i);
        bus.up_a_valid_i = 1'b0;
        bus.dn_a_ready_i = 1'b0;
        bus.dn_d_valid_i = 1'b0;
        bus.up_d_ready_i = 1'b0;
        o.validAfter     = bus.up_d_valid_o;
    endtask

    task automatic checkAgainstModel(input string tag, input reqT r, input expT e, input obsT o);
        checkOutput({tag, ".beats"}, 128'(o.nBeats), 128'(e.nBeats));
        for (int k = 0; k < e.nBeats; k++) begin
            checkOutput($sformatf("%s.beat%0d", tag, k), 128'(o.beats[k]), 128'(e.beats[k]));
        end
        checkOutput({tag, ".upOpcode"}, 128'(o.uOp), 128'(e.uOp));
        checkOutput({tag, ".upData"}, 128'(o.uData), 128'(e.uData));
        checkOutput({tag, ".upError"}, 128'(o.uErr), 128'(e.uErr));
        checkOutput({tag, ".upSize"}, 128'(o.uSize), 128'(r.size));
        checkOutput({tag, ".upSource"}, 128'(o.uSrc), 128'(r.src));
        checkOutput({tag, ".stable"}, 128'(o.unstable), 128'(0));
        checkOutput({tag, ".acceptNow"}, 128'(o.acceptWait), 128'(0));
        checkOutput({tag, ".timeout"}, 128'(o.timedOut), 128'(0));
        checkOutput({tag, ".singleRsp"}, 128'(o.validAfter), 128'(0));
    endtask

    // Main sequence: reset, directed table, mid-transaction reset, random traffic
    initial begin
        vecT         vecs[7];
        obsT         o;
        expT         e;
        reqT         r;
        bit          reached;
        bit          lastHi;
        logic [31:0] w0, w1;
        logic        e0, e1;
        string       tag;

        vecs[0] = '{reqT'{3'd4, 2'd3, 8'h11, 32'h1000_0008, 8'hFF, 64'h0},
                    32'h1111_2222, 32'h3333_4444, 1'b0, 1'b0, 0, 0, 2,
                    32'h1000_0008, 32'h1000_000C, 4'hF, 3'd4, 2'd2, 32'h0,
                    3'd1, 64'h3333_4444_1111_2222, 1'b0, 5};
        vecs[1] = '{reqT'{3'd1, 2'd1, 8'h22, 32'h20, 8'h30, 64'hAABB_CCDD_0000_0000},
                    32'h0, 32'h0, 1'b0, 1'b0, 0, 0, 1,
                    32'h24, 32'h0, 4'h3, 3'd1, 2'd1, 32'hAABB_CCDD,
                    3'd0, 64'h0, 1'b0, 3};
        vecs[2] = '{reqT'{3'd0, 2'd3, 8'h5A, 32'h44, 8'hFF, 64'h0123_4567_89AB_CDEF},
                    32'h0, 32'h0, 1'b0, 1'b0, 0, 0, 0,
                    32'h0, 32'h0, 4'h0, 3'd0, 2'd0, 32'h0,
                    3'd0, 64'h0, 1'b1, 1};
        vecs[3] = '{reqT'{3'd4, 2'd3, 8'h33, 32'h200, 8'hFF, 64'h0},
                    32'hDEAD_BEEF, 32'hCAFE_F00D, 1'b1, 1'b0, 0, 0, 2,
                    32'h200, 32'h204, 4'hF, 3'd4, 2'd2, 32'h0,
                    3'd1, 64'hCAFE_F00D_DEAD_BEEF, 1'b1, 5};
        vecs[4] = '{reqT'{3'd0, 2'd2, 8'h44, 32'h104, 8'hF0, 64'h1234_5678_9ABC_DEF0},
                    32'h0, 32'h0, 1'b0, 1'b0, 5, 3, 1,
                    32'h104, 32'h0, 4'hF, 3'd0, 2'd2, 32'h1234_5678,
                    3'd0, 64'h0, 1'b0, 0};
        vecs[5] = '{reqT'{3'd4, 2'd0, 8'h66, 32'h3, 8'h08, 64'h0},
                    32'h5566_7788, 32'h9999_9999, 1'b0, 1'b1, 0, 0, 1,
                    32'h3, 32'h0, 4'h8, 3'd4, 2'd0, 32'h0,
                    3'd1, 64'h0000_0000_5566_7788, 1'b0, 3};
        vecs[6] = '{reqT'{3'd4, 2'd3, 8'h77, 32'h8, 8'h00, 64'h0},
                    32'h1, 32'h2, 1'b0, 1'b0, 0, 0, 0,
                    32'h0, 32'h0, 4'h0, 3'd0, 2'd0, 32'h0,
                    3'd1, 64'h0, 1'b1, 1};

        checkCount = 0;
        passCount  = 0;
        rst_ni               = 1'b0;
        bus.up_a_valid_i     = 1'b0;
        bus.up_a_opcode_i    = '0;
        bus.up_a_size_i      = '0;
        bus.up_a_source_i    = '0;
        bus.up_a_address_i   = '0;
        bus.up_a_mask_i      = '0;
        bus.up_a_data_i      = '0;
        bus.up_d_ready_i     = 1'b0;
        bus.dn_a_ready_i     = 1'b0;
        bus.dn_d_valid_i     = 1'b0;
        bus.dn_d_data_i      = '0;
        bus.dn_d_error_i     = 1'b0;

        repeat (3) @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        checkOutput("reset.upAReady", 128'(bus.up_a_ready_o), 128'(1));
        checkOutput("reset.upDValid", 128'(bus.up_d_valid_o), 128'(0));
        checkOutput("reset.dnAValid", 128'(bus.dn_a_valid_o), 128'(0));
        checkOutput("reset.dnDReady", 128'(bus.dn_d_ready_o), 128'(0));
        checkOutput("reset.upDData", 128'(bus.up_d_data_o), 128'(0));
        checkOutput("reset.upDSource", 128'(bus.up_d_source_o), 128'(0));

        for (int i = 0; i < 7; i++) begin
            tag = $sformatf("vec%0d", i);
            applyStimulus(vecs[i].req, vecs[i].w0, vecs[i].w1, vecs[i].e0, vecs[i].e1,
                          vecs[i].aDly, 0, vecs[i].upDly, 1'b0, o);
            checkOutput({tag, ".beats"}, 128'(o.nBeats), 128'(vecs[i].expBeats));
            if (vecs[i].expBeats > 0) begin
                checkOutput({tag, ".addr0"}, 128'(o.beats[0].addr), 128'(vecs[i].expAddr0));
                checkOutput({tag, ".mask0"}, 128'(o.beats[0].mask), 128'(vecs[i].expMask0));
                checkOutput({tag, ".op0"}, 128'(o.beats[0].op), 128'(vecs[i].expOp0));
                checkOutput({tag, ".size0"}, 128'(o.beats[0].size), 128'(vecs[i].expSize0));
                checkOutput({tag, ".data0"}, 128'(o.beats[0].data), 128'(vecs[i].expData0));
                checkOutput({tag, ".src0"}, 128'(o.beats[0].src), 128'(vecs[i].req.src));
            end
            if (vecs[i].expBeats > 1) begin
                checkOutput({tag, ".addr1"}, 128'(o.beats[1].addr), 128'(vecs[i].expAddr1));
            end
            checkOutput({tag, ".upOpcode"}, 128'(o.uOp), 128'(vecs[i].expUpOp));
            checkOutput({tag, ".upData"}, 128'(o.uData), 128'(vecs[i].expUpData));
            checkOutput({tag, ".upError"}, 128'(o.uErr), 128'(vecs[i].expUpErr));
            checkOutput({tag, ".upSize"}, 128'(o.uSize), 128'(vecs[i].req.size));
            checkOutput({tag, ".upSource"}, 128'(o.uSrc), 128'(vecs[i].req.src));
            checkOutput({tag, ".stable"}, 128'(o.unstable), 128'(0));
            checkOutput({tag, ".timeout"}, 128'(o.timedOut), 128'(0));
            checkOutput({tag, ".singleRsp"}, 128'(o.validAfter), 128'(0));
            checkOutput({tag, ".acceptNow"}, 128'(o.acceptWait), 128'(0));
            if (vecs[i].expLat != 0) begin
                checkOutput({tag, ".latency"}, 128'(o.latency), 128'(vecs[i].expLat));
            end
        end

        // Reset while the upper beat's response is outstanding
        bus.up_a_valid_i   = 1'b1;
        bus.up_a_opcode_i  = 3'd4;
        bus.up_a_size_i    = 2'd3;
        bus.up_a_source_i  = 8'h99;
        bus.up_a_address_i = 32'h300;
        bus.up_a_mask_i    = 8'hFF;
        bus.up_a_data_i    = 64'h0;
        @(posedge clk_i);
        reached = 0;
        lastHi  = 0;
        for (int k = 0; k < 40 && !reached; k++) begin
            @(negedge clk_i);
            bus.up_a_valid_i = 1'b0;
            if (bus.dn_d_ready_o && lastHi) begin
                reached = 1;
            end else begin
                bus.dn_a_ready_i = bus.dn_a_valid_o;
                if (bus.dn_a_valid_o) lastHi = bus.dn_a_address_o[2];
                bus.dn_d_valid_i = bus.dn_d_ready_o;
                bus.dn_d_data_i  = 32'h7777_0000;
                bus.dn_d_error_i = 1'b0;
                @(posedge clk_i);
            end
        end
        checkOutput("rst.reachedHiRsp", 128'(reached), 128'(1));
        bus.dn_a_ready_i = 1'b0;
        bus.dn_d_valid_i = 1'b0;
        #2;
        rst_ni = 1'b0;
        #1;
        checkOutput("rst.upDValid", 128'(bus.up_d_valid_o), 128'(0));
        checkOutput("rst.dnAValid", 128'(bus.dn_a_valid_o), 128'(0));
        checkOutput("rst.dnDReady", 128'(bus.dn_d_ready_o), 128'(0));
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        checkOutput("rst.upAReady", 128'(bus.up_a_ready_o), 128'(1));
        r = '{op: 3'd4, size: 2'd3, src: 8'hA5, addr: 32'h0000_0310, mask: 8'hFF, data: 64'h0};
        applyStimulus(r, 32'h0102_0304, 32'h0506_0708, 1'b0, 1'b0, 0, 0, 0, 1'b0, o);
        checkAgainstModel("rst.after", r, model(r, 32'h0102_0304, 32'h0506_0708, 1'b0, 1'b0), o);

        // Randomized traffic, including ignored upstream/downstream valids
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 7))
                0, 1, 2: r.op = 3'd0;
                3, 4:    r.op = 3'd1;
                5, 6:    r.op = 3'd4;
                default: r.op = 3'($urandom_range(5, 7));
            endcase
            r.size = 2'($urandom_range(0, 3));
            r.src  = 8'($urandom);
            r.addr = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (r.size == 2'd3) r.addr = r.addr & 32'hFFFF_FFF8;
                if (r.size == 2'd2) r.addr = r.addr & 32'hFFFF_FFFC;
            end
            r.mask = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            r.data = {$urandom, $urandom};
            w0 = $urandom;
            w1 = $urandom;
            e0 = ($urandom_range(0, 5) == 0);
            e1 = ($urandom_range(0, 5) == 0);
            e  = model(r, w0, w1, e0, e1);
            applyStimulus(r, w0, w1, e0, e1, $urandom_range(0, 3), $urandom_range(0, 2),
                          $urandom_range(0, 3), 1'($urandom_range(0, 1)), o);
            checkAgainstModel($sformatf("rand%0d", n), r, e, o);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
